ci_vector_sequencer: RTL and testbench

//  Initiator side of the function_evaluation custom-instruction handshake (clk_en/start/n/done/result).

---
 rtl/ci_vector_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ci_vector_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ci_vector_sequencer
// Buffers IEEE-754 singles and drives one CLEAR / GO... / READ custom-instruction pass.
// Rev    : 1.0  initial release
// ============================================================================
module ci_vector_sequencer #(
  parameter int                        FLT_DATA_WIDTH = 32,
  parameter int                        N_WIDTH        = 2,
  parameter int                        DEPTH          = 16,
  parameter int                        CNT_WIDTH      = 5,
  parameter logic [FLT_DATA_WIDTH-1:0] PAD_VALUE      = '0,
  parameter int                        TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [FLT_DATA_WIDTH-1:0] in_data,
  output logic                      in_ready,
  input  logic                      go,
  output logic                      busy,
  output logic                      result_valid,
  output logic [FLT_DATA_WIDTH-1:0] result,
  output logic                      error,
  output logic                      ci_clk_en,
  output logic                      ci_start,
  output logic [N_WIDTH-1:0]        ci_n,
  output logic [FLT_DATA_WIDTH-1:0] ci_dataa,
  output logic [FLT_DATA_WIDTH-1:0] ci_datab,
  input  logic                      ci_done,
  input  logic [FLT_DATA_WIDTH-1:0] ci_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [N_WIDTH-1:0] OP_CLEAR = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] OP_GO    = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] OP_READ  = N_WIDTH'(2);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [N_WIDTH-1:0]        op_q, op_d;
  logic [FLT_DATA_WIDTH-1:0] dataa_q, dataa_d;
  logic [FLT_DATA_WIDTH-1:0] datab_q, datab_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [CNT_WIDTH-1:0]      rem_q, rem_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [FLT_DATA_WIDTH-1:0] result_q, result_d;
  logic                      error_q, error_d;
  logic [FLT_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic w_busy;
  logic w_push;
  logic w_take2;
  logic w_active;

  assign w_busy   = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_GAP);
  assign w_push   = in_valid && in_ready;
  assign w_take2  = (rem_q > CNT_WIDTH'(1));
  assign w_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign in_ready     = !w_busy && (count_q < CNT_WIDTH'(DEPTH));
  assign busy         = w_busy;
  assign result_valid = (state_q == ST_CAPTURE);
  assign result       = result_q;
  assign error        = error_q;
  assign ci_start     = (state_q == ST_ISSUE);
  assign ci_clk_en    = w_active;
  assign ci_n         = w_active ? op_q    : '0;
  assign ci_dataa     = w_active ? dataa_q : '0;
  assign ci_datab     = w_active ? datab_q : '0;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dataa_d  = dataa_q;
    datab_d  = datab_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          // An element pushed in the same cycle as go belongs to this pass.
          rem_d   = count_q + CNT_WIDTH'(w_push);
          error_d = 1'b0;
          op_d    = OP_CLEAR;
          dataa_d = '0;
          datab_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ci_done) begin
          if (op_q == OP_READ) begin
            result_d = ci_result;
            state_d  = ST_CAPTURE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (rem_q != '0) begin
          op_d     = OP_GO;
          dataa_d  = mem_q[rd_ptr_q];
          datab_d  = w_take2 ? mem_q[rd_ptr_q + AW'(1)] : PAD_VALUE;
          rd_ptr_d = rd_ptr_q + (w_take2 ? AW'(2) : AW'(1));
          count_d  = count_q - (w_take2 ? CNT_WIDTH'(2) : CNT_WIDTH'(1));
          rem_d    = rem_q - (w_take2 ? CNT_WIDTH'(2) : CNT_WIDTH'(1));
        end else begin
          op_d    = OP_READ;
          dataa_d = '0;
          datab_d = '0;
        end
        state_d = ST_ISSUE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        rd_ptr_d = wr_ptr_q;
        count_d  = '0;
        rem_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pushes only happen outside ISSUE/WAIT/GAP, so they never race a pop.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ci_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ci_vector_sequencer
// Directed and randomized passes against a queue-based model and a behavioural responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ci_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        go;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        error;
  logic        ci_clk_en;
  logic        ci_start;
  logic [1:0]  ci_n;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic        ci_done = 1'b0;
  logic [31:0] ci_result = 32'h0;

  ci_vector_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .go(go), .busy(busy), .result_valid(result_valid), .result(result), .error(error),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_done(ci_done), .ci_result(ci_result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_q[$];
  logic [65:0] ops_log[$];
  logic [65:0] exp_ops[$];

  int K = 4;
  bit hang = 1'b0;
  int pend = 0;
  int wcnt = 0;
  int cyc = 0;
  int last_start = -100;
  int min_gap = 1000;
  bit rd_done_flag = 1'b0;
  int rv_bad = 0;
  int rv_count = 0;
  bit prev_err = 1'b0;
  int err_cyc = 0;
  int go_start_cyc = 0;

  // Monitor and responder share one process so check/update order is fixed.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ci_done      = 1'b0;
      pend         = 0;
      rd_done_flag = 1'b0;
      prev_err     = 1'b0;
    end else begin
      if (result_valid !== rd_done_flag) rv_bad++;
      if (result_valid) rv_count++;
      if (error && !prev_err) err_cyc = cyc;
      prev_err = error;
      if (ci_start) begin
        ops_log.push_back({ci_n, ci_dataa, ci_datab});
        if (cyc - last_start < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
        if (ci_n == 2'd1) go_start_cyc = cyc;
      end
      ci_done = 1'b0;
      if (ci_start) begin
        pend = 1;
        wcnt = K;
      end else if (pend != 0) begin
        wcnt--;
        if (wcnt == 0) begin
          pend = 0;
          if (!(hang && ci_n == 2'd1)) begin
            ci_done   = 1'b1;
            ci_result = (ci_n == 2'd2) ? 32'hC0FFEE00 : $urandom;
          end
        end
      end
      rd_done_flag = ci_done && ci_clk_en && !ci_start && (ci_n == 2'd2);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_elem(input logic [31:0] v);
    bit exp_rdy;
    exp_rdy = (model_q.size() < 16);
    chk("in_ready", 96'(in_ready), 96'(exp_rdy));
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    if (exp_rdy) model_q.push_back(v);
  endtask

  task automatic run_pass(input string tag, input int kk, input bit hg, input bit inject);
    logic [31:0] a, b, old_result;
    int n;
    K = kk;
    hang = hg;
    ops_log.delete();
    exp_ops.delete();
    min_gap = 1000;
    rv_count = 0;
    rv_bad = 0;
    last_start = -100;
    old_result = result;

    exp_ops.push_back({2'd0, 32'h0, 32'h0});
    if (hg) begin
      if (model_q.size() > 0) begin
        a = model_q.pop_front();
        b = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
        exp_ops.push_back({2'd1, a, b});
      end
      model_q.delete();
    end else begin
      while (model_q.size() > 0) begin
        a = model_q.pop_front();
        b = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
        exp_ops.push_back({2'd1, a, b});
      end
      exp_ops.push_back({2'd2, 32'h0, 32'h0});
    end

    go = 1'b1;
    tick();
    go = 1'b0;
    chk({tag, "_busy_after_go"}, 96'(busy), 96'(1));
    chk({tag, "_error_cleared"}, 96'(error), 96'(0));
    if (inject) begin
      tick();
      chk({tag, "_in_ready_busy"}, 96'(in_ready), 96'(0));
      go       = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      go       = 1'b0;
      in_valid = 1'b0;
    end
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_pass_ends"}, 96'(n < 3000), 96'(1));
    tick();
    tick();

    chk({tag, "_op_count"}, 96'(ops_log.size()), 96'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < ops_log.size(); i++)
      chk($sformatf("%s_op%0d", tag, i), 96'(ops_log[i]), 96'(exp_ops[i]));
    chk({tag, "_start_spacing"}, 96'(min_gap >= 3), 96'(1));
    chk({tag, "_rv_timing"}, 96'(rv_bad), 96'(0));
    chk({tag, "_in_ready_after"}, 96'(in_ready), 96'(1));
    if (hg) begin
      chk({tag, "_error"}, 96'(error), 96'(1));
      chk({tag, "_rv_count"}, 96'(rv_count), 96'(0));
      chk({tag, "_result_kept"}, 96'(result), 96'(old_result));
      chk({tag, "_timeout_len"}, 96'(err_cyc - go_start_cyc), 96'(1024));
    end else begin
      chk({tag, "_error"}, 96'(error), 96'(0));
      chk({tag, "_rv_count"}, 96'(rv_count), 96'(1));
      chk({tag, "_result"}, 96'(result), 96'(32'hC0FFEE00));
    end
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    go       = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 96'(in_ready), 96'(1));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_rv", 96'(result_valid), 96'(0));
    chk("rst_result", 96'(result), 96'(0));
    chk("rst_error", 96'(error), 96'(0));
    chk("rst_ci", 96'({ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab}), 96'(0));
    rst = 1'b0;
    tick();

    // Two elements, one GO.
    push_elem(32'h3F800000);
    push_elem(32'h40000000);
    run_pass("t1", 4, 1'b0, 1'b0);

    // Odd count pads datab.
    push_elem(32'h3F800000);
    push_elem(32'h40000000);
    push_elem(32'h40400000);
    run_pass("t2", 3, 1'b0, 1'b0);

    // Overfill: 17th element dropped.
    for (int i = 0; i < 17; i++) push_elem($urandom);
    chk("t3_full_ready", 96'(in_ready), 96'(0));
    run_pass("t3", 2, 1'b0, 1'b0);

    // Responder hangs on GO, then a clean recovery pass.
    push_elem(32'h11111111);
    push_elem(32'h22222222);
    run_pass("t4", 2, 1'b1, 1'b0);
    run_pass("t4b", 2, 1'b0, 1'b0);

    // Empty buffer with go/push attempts while busy.
    run_pass("t5", 5, 1'b0, 1'b1);
    push_elem(32'h3F800000);
    run_pass("t5b", 1, 1'b0, 1'b0);

    // Reset during WAIT of the second GO.
    for (int i = 0; i < 4; i++) push_elem($urandom);
    K = 6;
    hang = 1'b0;
    ops_log.delete();
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (ops_log.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_reach_go2", 96'(n < 200), 96'(1));
    tick();
    chk("t6_in_wait", 96'({ci_clk_en, ci_start}), 96'(2'b10));
    rst = 1'b1;
    tick();
    chk("t6_start", 96'(ci_start), 96'(0));
    chk("t6_clk_en", 96'(ci_clk_en), 96'(0));
    chk("t6_busy", 96'(busy), 96'(0));
    chk("t6_in_ready", 96'(in_ready), 96'(1));
    rst = 1'b0;
    model_q.delete();
    tick();
    run_pass("t6b", 2, 1'b0, 1'b0);

    // Randomized passes.
    for (int p = 0; p < 4; p++) begin
      int cnt;
      cnt = $urandom_range(0, 16);
      for (int i = 0; i < cnt; i++) push_elem($urandom);
      run_pass($sformatf("rnd%0d", p), $urandom_range(1, 5), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
